// File: rtl/qamdemod_pkg.sv
// Shared widths, Gray level codes and the arm slicer for the 16-QAM receiver.
package qam_pkg;

  localparam int N      = 16;
  localparam int RX_W   = 17;
  localparam int CAR_W  = 12;
  localparam int P_W    = RX_W + CAR_W;
  localparam int ACC_W  = P_W + $clog2(N);
  localparam int CNT_W  = $clog2(N);
  localparam int HOLD_W = $clog2(N);

  localparam logic [1:0] L_M3 = 2'b00;
  localparam logic [1:0] L_M1 = 2'b01;
  localparam logic [1:0] L_P1 = 2'b11;
  localparam logic [1:0] L_P3 = 2'b10;

  typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

  // Four-level Gray decision; the threshold is symmetric about zero.
  function automatic logic [1:0] slice_level(input logic signed [ACC_W-1:0] d,
                                             input logic [ACC_W-2:0] thr);
    logic signed [ACC_W-1:0] t;
    t = $signed({1'b0, thr});
    if (d < -t)             return L_M3;
    else if (d[ACC_W-1])    return L_M1;
    else if (d < t)         return L_P1;
    else                    return L_P3;
  endfunction

endpackage

// File: rtl/qamdemod_if.sv
// Sample/carrier inputs and recovered-symbol outputs of the 16-QAM receiver.
interface qamdemod_if;
  import qam_pkg::*;

  logic signed [RX_W-1:0]  rxsignal;
  logic signed [CAR_W-1:0] cos;
  logic signed [CAR_W-1:0] sin;
  logic                    sym_start;
  logic [ACC_W-2:0]        thr;
  logic [1:0]              bitsa;
  logic [1:0]              bitsb;
  logic                    sym_valid;
  logic                    outputsignal;
  logic                    bit_valid;

  modport master (output rxsignal, cos, sin, sym_start, thr,
                  input  bitsa, bitsb, sym_valid, outputsignal, bit_valid);
  modport slave  (input  rxsignal, cos, sin, sym_start, thr,
                  output bitsa, bitsb, sym_valid, outputsignal, bit_valid);

endinterface

// File: rtl/qamdemod_arm.sv
// One receiver arm: carrier multiply, integrate-and-dump over a symbol, Gray slicer.
module qamarm
  import qam_pkg::*;
(
  input  logic                    clk_16,
  input  logic                    rst,
  input  logic signed [RX_W-1:0]  rx,
  input  logic signed [CAR_W-1:0] car,
  input  logic                    first,
  input  logic                    last,
  input  logic [ACC_W-2:0]        thr,
  output logic [1:0]              bits,
  output logic                    dump
);

  logic signed [P_W-1:0]   p;
  logic                    p_first;
  logic                    p_last;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] p_ext;
  logic signed [ACC_W-1:0] d;

  assign p_ext = $signed({{(ACC_W-P_W){p[P_W-1]}}, p});
  // First sample of a symbol replaces the accumulator, so a resync drops any partial sum.
  assign d     = p_first ? p_ext : acc + p_ext;

  always_ff @(posedge clk_16) begin
    if (rst) begin
      p       <= '0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      acc     <= '0;
      bits    <= L_M3;
      dump    <= 1'b0;
    end else begin
      p       <= P_W'(rx) * P_W'(car);
      p_first <= first;
      p_last  <= last;
      acc     <= d;
      dump    <= p_last;
      if (p_last) bits <= slice_level(d, thr);
    end
  end

endmodule

// File: rtl/qamdemod.sv
// 16-QAM receiver top: sample index/flags, two integrate-and-dump arms, bit serialiser.
// state   | meaning
// S_IDLE  | no bits pending, outputsignal holds the last bit sent
// S_SHIFT | presenting recovered bits MSB first, each held N/4 cycles
module qamdemod
  import qam_pkg::*;
(
  input  logic       clk_16,
  input  logic       rst,
  qamdemod_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(N/4 - 1);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  idx;
  logic              first;
  logic              last;
  logic [1:0]        bits_i;
  logic [1:0]        bits_q;
  logic              dump_i;
  logic              dump_q;
  logic              sym_valid;
  ser_state_t        state;
  logic [2:0]        sr;
  logic [1:0]        bits_left;
  logic [HOLD_W-1:0] hold;
  logic              ser_out;
  logic              ser_valid;

  assign idx   = bus.sym_start ? '0 : cnt;
  assign first = (idx == '0);
  assign last  = (idx == CNT_W'(N-1));

  always_ff @(posedge clk_16) begin
    if (rst) cnt <= '0;
    else     cnt <= last ? '0 : idx + CNT_W'(1);
  end

  qamarm u_arm_i (.clk_16(clk_16), .rst(rst), .rx(bus.rxsignal), .car(bus.cos),
                  .first(first), .last(last), .thr(bus.thr), .bits(bits_i), .dump(dump_i));
  qamarm u_arm_q (.clk_16(clk_16), .rst(rst), .rx(bus.rxsignal), .car(bus.sin),
                  .first(first), .last(last), .thr(bus.thr), .bits(bits_q), .dump(dump_q));

  assign sym_valid = dump_i & dump_q;

  // A new symbol always restarts the shifter, even mid-word.
  always_ff @(posedge clk_16) begin
    if (rst) begin
      state     <= S_IDLE;
      sr        <= '0;
      bits_left <= '0;
      hold      <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      ser_valid <= 1'b0;
      if (sym_valid) begin
        state     <= S_SHIFT;
        ser_out   <= bits_i[1];
        sr        <= {bits_i[0], bits_q};
        bits_left <= 2'd3;
        hold      <= HOLD_MAX;
        ser_valid <= 1'b1;
      end else begin
        case (state)
          S_SHIFT: begin
            if (hold != '0) begin
              hold <= hold - HOLD_W'(1);
            end else if (bits_left == 2'd0) begin
              state <= S_IDLE;
            end else begin
              ser_out   <= sr[2];
              sr        <= {sr[1:0], 1'b0};
              bits_left <= bits_left - 2'd1;
              hold      <= HOLD_MAX;
              ser_valid <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.bitsa        = bits_i;
  assign bus.bitsb        = bits_q;
  assign bus.sym_valid    = sym_valid;
  assign bus.outputsignal = ser_out;
  assign bus.bit_valid    = ser_valid;

endmodule

// File: tb/tb_qamdemod.sv
// Scoreboard bench for qamdemod: symbols are queued as driven and checked on sym_valid.
module tb_qamdemod;
  import qam_pkg::*;

  logic clk_16 = 1'b0;
  logic rst;

  qamdemod_if bus();

  qamdemod dut (.clk_16(clk_16), .rst(rst), .bus(bus.slave));

  always #5 clk_16 = ~clk_16;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [3:0] exp_q[$];
  int         gap_err = 0;
  int         last_sv = 0;
  bit         have_prev = 0;
  bit         gap_chk = 0;

  always @(posedge clk_16) cyc <= cyc + 1;

  always @(negedge clk_16) begin : monitor
    logic [3:0] e;
    if (bus.sym_valid === 1'b1) begin
      if (gap_chk && have_prev && (cyc - last_sv) != N) gap_err++;
      last_sv   = cyc;
      have_prev = 1'b1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sym_bits: got %b_%b, no symbol expected", bus.bitsa, bus.bitsb);
      end else begin
        e = exp_q.pop_front();
        if ({bus.bitsa, bus.bitsb} !== e) begin
          n_bad++;
          $display("FAIL sym_bits: got %b_%b expected %b_%b", bus.bitsa, bus.bitsb, e[3:2], e[1:0]);
        end
      end
    end
  end

  function automatic logic [1:0] gray(input int a);
    case (a)
      -3:      return 2'b00;
      -1:      return 2'b01;
      1:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic drive(input int rx, input int c, input int s, input logic ss);
    @(negedge clk_16);
    rst           = 1'b0;
    bus.rxsignal  = RX_W'(rx);
    bus.cos       = CAR_W'(c);
    bus.sin       = CAR_W'(s);
    bus.sym_start = ss;
  endtask

  task automatic send_sym(input int rx, input int c, input int s, input logic [3:0] e);
    exp_q.push_back(e);
    for (int i = 0; i < N; i++) drive(rx, c, s, 1'b0);
  endtask

  task automatic end_test(input string name);
    repeat (3) @(negedge clk_16);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_pending: %0d symbols never produced, expected 0", name, exp_q.size());
    end
    exp_q.delete();
    rst = 1'b1;
    repeat (2) @(negedge clk_16);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_16);
    n_cmp++; if (bus.bitsa !== 2'b00)       begin n_bad++; $display("FAIL reset_bitsa: got %b expected 00", bus.bitsa); end
    n_cmp++; if (bus.bitsb !== 2'b00)       begin n_bad++; $display("FAIL reset_bitsb: got %b expected 00", bus.bitsb); end
    n_cmp++; if (bus.sym_valid !== 1'b0)    begin n_bad++; $display("FAIL reset_sym_valid: got %b expected 0", bus.sym_valid); end
    n_cmp++; if (bus.outputsignal !== 1'b0) begin n_bad++; $display("FAIL reset_out: got %b expected 0", bus.outputsignal); end
    n_cmp++; if (bus.bit_valid !== 1'b0)    begin n_bad++; $display("FAIL reset_bit_valid: got %b expected 0", bus.bit_valid); end
  endtask

  // Back-to-back directed symbols including both threshold edges on each arm.
  task automatic test_slicer();
    int         t_rx[9]  = '{100, -100, 50, 125, -125, 124, -126, 125, -125};
    int         t_c[9]   = '{1000, 1000, 0, 500, 500, 500, 500, 0, 0};
    int         t_s[9]   = '{0, 0, 1000, 0, 0, 0, 0, 500, 500};
    logic [3:0] t_e[9]   = '{4'b1011, 4'b0011, 4'b1111, 4'b1011, 4'b0111,
                             4'b1111, 4'b0011, 4'b1110, 4'b1101};
    for (int k = 0; k < 9; k++) send_sym(t_rx[k], t_c[k], t_s[k], t_e[k]);
    end_test("slicer");
  endtask

  task automatic test_serial();
    logic [3:0] sb = 4'b1011;
    fork
      begin
        send_sym(100, 1000, 0, 4'b1011);
        send_sym(-100, 1000, 0, 4'b0011);
      end
      begin : observe
        int   k = 0;
        logic [2:0] ex;
        do begin @(negedge clk_16); k++; end while (bus.sym_valid !== 1'b1 && k < 64);
        n_cmp++;
        if (k >= 64) begin
          n_bad++;
          $display("FAIL serial_timeout: no sym_valid within %0d cycles", k);
        end else begin
          for (int j = 1; j <= 16; j++) begin
            @(negedge clk_16);
            ex = {j == 16, ((j - 1) % 4) == 0, sb[3 - (j - 1) / 4]};
            n_cmp++;
            if ({bus.sym_valid, bus.bit_valid, bus.outputsignal} !== ex) begin
              n_bad++;
              $display("FAIL serial_c%0d: got sv/bv/out %b%b%b expected %b", j,
                       bus.sym_valid, bus.bit_valid, bus.outputsignal, ex);
            end
          end
        end
      end
    join
    end_test("serial");
  endtask

  task automatic test_resync();
    for (int i = 0; i < 7; i++) drive(-100, 1000, 0, 1'b0);
    exp_q.push_back(4'b1011);
    drive(100, 1000, 0, 1'b1);
    for (int i = 0; i < N - 1; i++) drive(100, 1000, 0, 1'b0);
    @(negedge clk_16);
    n_cmp++; if (bus.sym_valid !== 1'b0) begin n_bad++; $display("FAIL resync_early: got %b expected 0", bus.sym_valid); end
    @(negedge clk_16);
    n_cmp++; if (bus.sym_valid !== 1'b1) begin n_bad++; $display("FAIL resync_valid: got %b expected 1", bus.sym_valid); end
    end_test("resync");
  endtask

  task automatic test_reset_mid();
    send_sym(100, 1000, 0, 4'b1011);
    for (int i = 0; i < 9; i++) drive(100, 1000, 0, 1'b0);
    @(negedge clk_16);
    rst = 1'b1;
    @(negedge clk_16);
    n_cmp++;
    if ({bus.bitsa, bus.bitsb, bus.sym_valid, bus.outputsignal, bus.bit_valid} !== 7'b0) begin
      n_bad++;
      $display("FAIL rstmid_clear: got %b%b%b%b%b expected 0000000", bus.bitsa, bus.bitsb,
               bus.sym_valid, bus.outputsignal, bus.bit_valid);
    end
    send_sym(100, 1000, 0, 4'b1011);
    @(negedge clk_16);
    n_cmp++; if (bus.sym_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_early: got %b expected 0", bus.sym_valid); end
    @(negedge clk_16);
    n_cmp++; if (bus.sym_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid_valid: got %b expected 1", bus.sym_valid); end
    end_test("rstmid");
  endtask

  // I carrier 1,0,-1,0 and Q carrier 0,1,0,-1 give acc = 200_000 * level on each arm.
  task automatic test_random();
    int lv[4]   = '{-3, -1, 1, 3};
    int cosn[4] = '{1, 0, -1, 0};
    int sinn[4] = '{0, 1, 0, -1};
    int ai, aq;
    bus.thr   = (ACC_W-1)'(400_000);
    gap_err   = 0;
    have_prev = 1'b0;
    gap_chk   = 1'b1;
    for (int s = 0; s < 20; s++) begin
      ai = lv[$urandom_range(0, 3)];
      aq = lv[$urandom_range(0, 3)];
      exp_q.push_back({gray(ai), gray(aq)});
      for (int i = 0; i < N; i++)
        drive(25 * (ai * cosn[i % 4] + aq * sinn[i % 4]), 1000 * cosn[i % 4], 1000 * sinn[i % 4], 1'b0);
    end
    end_test("random");
    gap_chk = 1'b0;
    n_cmp++;
    if (gap_err !== 0) begin
      n_bad++;
      $display("FAIL random_gap: %0d sym_valid gaps not %0d cycles, expected 0", gap_err, N);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.rxsignal  = '0;
    bus.cos       = '0;
    bus.sin       = '0;
    bus.sym_start = 1'b0;
    bus.thr       = (ACC_W-1)'(1_000_000);
    test_reset();
    test_slicer();
    test_serial();
    test_resync();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared so far", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/qamdemod.md
# qamdemod

16-QAM receiver matching the team's 16-QAM modulator: takes the received passband sample stream plus local cos/sin carriers at clk_16 rate and integrates I and Q products over one symbol period. At symbol end it slices each arm to a 2-bit level and re-serialises the 4 recovered bits. Sits after the channel/ADC model, mirroring the modulator's bitsa/bitsb/serial interface in the opposite direction.

## Interface
- N, 16, samples per symbol; multiple of 4, ≥4
- RX_W, 17, signed width of rxsignal (sum of two 16-bit modulator products)
- CAR_W, 12, signed carrier width
- ACC_W, RX_W+CAR_W+log2(N) = 33, signed accumulator width
- clk_16  in  1  sample clock
- rst  in  1  synchronous, active-high reset
- rxsignal  in  RX_W  signed received sample
- cos  in  CAR_W  signed local in-phase carrier
- sin  in  CAR_W  signed local quadrature carrier
- sym_start  in  1  current sample is index 0 of a new symbol (resync)
- thr  in  ACC_W-1  unsigned decision threshold, static while running
- bitsa  out  2  recovered I symbol bits
- bitsb  out  2  recovered Q symbol bits
- sym_valid  out  1  one-cycle pulse, bitsa/bitsb updated
- outputsignal  out  1  serial recovered bitstream
- bit_valid  out  1  one-cycle pulse at start of each serial bit

## Operation
- Sample counter cnt 0..N-1; wraps N-1→0. sym_start forces current sample to index 0 regardless of cnt. After rst, first sample is index 0.
- Stage 1 (registered): pI = rxsignal*cos, pQ = rxsignal*sin, full width RX_W+CAR_W signed; first/last flags travel with the products.
- Stage 2 (per arm): acc <= first ? p : acc+p, sign-extended to ACC_W, no saturation (ACC_W is overflow-free for N samples).
- On last: decision value d = (first ? p : acc+p); slicer registers bits, sym_valid pulses.
- Slicer (Gray): d < -thr → 00; -thr ≤ d < 0 → 01; 0 ≤ d < thr → 11; d ≥ thr → 10. Identical for both arms.
- sym_start mid-symbol: partial accumulation discarded, no sym_valid for the partial symbol.
- Serialiser: on sym_valid loads {bitsa,bitsb}; shifts MSB first (bitsa[1], bitsa[0], bitsb[1], bitsb[0]), each bit held N/4 cycles; bit_valid pulses on first cycle of each bit. New sym_valid while shifting reloads immediately and abandons the remaining bits. Idle: outputsignal holds last bit, bit_valid 0.

## Timing
- Reset values: bitsa=00, bitsb=00, sym_valid=0, outputsignal=0, bit_valid=0, cnt=0, acc=0, pipeline flags cleared.
- Latency: sample N-1 captured at edge E0; bitsa/bitsb/sym_valid update at E1 (two edges total). outputsignal first bit and bit_valid at E2.
- Back-to-back symbols seamless: sample 0 of next symbol captured at E0+1 loads acc at E1+1.
- Steady state: sym_valid period exactly N cycles; 4 bit_valid pulses per symbol spaced N/4.
- rst mid-symbol: all state cleared on that edge, in-flight symbol lost, no sym_valid.

## Structure
- Package qam_pkg: N, RX_W, CAR_W, ACC_W defaults; Gray level constants (L_M3=00, L_M1=01, L_P1=11, L_P3=10); slicer function.
- Sub-module qamarm (multiplier + integrate-and-dump + slicer), instantiated twice (cos, sin). Top holds counter, flag generation, serialiser.

## Test plan
- N=16, thr=1_000_000, cos=1000, sin=0, rx=100 ×16 → acc_I=1_600_000, bitsa=10, bitsb=11; serial 1,0,1,1 with 4 bit_valid pulses 4 cycles apart.
- cos=1000, rx=-100 → bitsa=00; sin=1000, cos=0, rx=50 → bitsb=11 (800_000), bitsa=11 (0).
- Boundaries: cos=500, rx=125 → d=1_000_000=thr → 10; rx=-125 → d=-thr → 01; d=0 → 11.
- sym_start at sample 7 of a symbol → no sym_valid at old boundary; next sym_valid 16 samples after resync, 2 edges after last sample.
- rst asserted at sample 9 → all outputs 0 next cycle; first sym_valid 16 samples + 2 edges after rst release.
- Continuous random symbols, ±3/±1 levels on both arms → recovered bitsa/bitsb match transmitted every 16 cycles, no gaps.
